key_debounce_2ch: RTL and testbench

KEY_DEBOUNCE_2CH -- requirements
Module: key_debounce_2ch

---
 rtl/key_debounce_2ch_pkg.sv | 19 +
 rtl/key_debounce_2ch_debounce_ch.sv | 117 +++++++++++
 rtl/key_debounce_2ch.sv | 41 ++++
 tb/tb_key_debounce_2ch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_2ch_pkg.sv
// Shared definitions for the two-channel key debouncer: channel FSM state
// encoding, the default stable-cycle count and the counter width helper.
package key_debounce_2ch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CNT   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CNT = 2'd3
    } db_state_e;

    // 20 ms of stability at a 50 MHz system clock.
    localparam logic [19:0] CNT_MAX_DEFAULT = 20'd1_000_000;

    function automatic int cnt_width(input logic [19:0] cnt_max);
        return $clog2(int'(cnt_max) + 32'sd1);
    endfunction

endpackage

// File: rtl/key_debounce_2ch_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM and a stable-sample
// counter. A level change is accepted after CNT_MAX consecutive agreeing samples.
module debounce_ch
    import key_debounce_2ch_pkg::*;
#(
    parameter logic [19:0] CNT_MAX    = CNT_MAX_DEFAULT,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic lvl_o,
    output logic press_o
);

    localparam int              CW        = cnt_width(CNT_MAX);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CNT_MAX - 20'd1);

    logic          sync1_q;
    logic          sync2_q;
    logic          key_s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;

    // Synchronizer idles at the released level so a key held through reset
    // still has to be counted from scratch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= ~KEY_ACTIVE;
            sync2_q <= ~KEY_ACTIVE;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = (sync2_q == KEY_ACTIVE);

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
        end
    end

    // Next-state logic; the sample that enters a counting state counts as one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d = ST_PRESS_CNT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_CNT: begin
                if (!key_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                    lvl_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!key_s) begin
                    state_d = ST_RELEASE_CNT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RELEASE_CNT: begin
                if (key_s) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    lvl_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                lvl_d   = 1'b0;
            end
        endcase
    end

    assign lvl_o   = lvl_q;
    assign press_o = press_q;

endmodule

// File: rtl/key_debounce_2ch.sv
// Two independent pushbutton debouncers producing registered levels and
// single-cycle press pulses for keys A and B.
module key_debounce_2ch
    import key_debounce_2ch_pkg::*;
#(
    parameter logic [19:0] CNT_MAX    = CNT_MAX_DEFAULT,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_a,
    input  logic key_b,
    output logic a_lvl,
    output logic b_lvl,
    output logic a_press,
    output logic b_press
);

    debounce_ch #(
        .CNT_MAX    (CNT_MAX),
        .KEY_ACTIVE (KEY_ACTIVE)
    ) u_ch_a (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .key_i   (key_a),
        .lvl_o   (a_lvl),
        .press_o (a_press)
    );

    debounce_ch #(
        .CNT_MAX    (CNT_MAX),
        .KEY_ACTIVE (KEY_ACTIVE)
    ) u_ch_b (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .key_i   (key_b),
        .lvl_o   (b_lvl),
        .press_o (b_press)
    );

endmodule

// File: tb/tb_key_debounce_2ch.sv
// Randomized and directed bench for key_debounce_2ch (CNT_MAX = 4, active-low
// keys) against a history-based reference model.
module tb_key_debounce_2ch;
    import key_debounce_2ch_pkg::*;

    localparam logic [19:0] CM  = 20'd4;
    localparam int          CMI = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_a, key_b;
    logic a_lvl, b_lvl, a_press, b_press;

    int n_vec = 0;
    int n_err = 0;

    // Model state: raw pressed history, synchronized sample history, and the
    // history index where each channel last changed level.
    logic [1:0] raw_h[$];
    logic [1:0] s_h[$];
    int         since [2];
    logic [1:0] m_lvl;
    logic [1:0] m_press;
    logic       prev_ap, prev_bp;

    always #5 sys_clk = ~sys_clk;

    key_debounce_2ch #(.CNT_MAX(CM), .KEY_ACTIVE(1'b0)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_a     (key_a),
        .key_b     (key_b),
        .a_lvl     (a_lvl),
        .b_lvl     (b_lvl),
        .a_press   (a_press),
        .b_press   (b_press)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        raw_h.delete();
        s_h.delete();
        since[0] = 0;
        since[1] = 0;
        m_lvl    = 2'b00;
        m_press  = 2'b00;
        prev_ap  = 1'b0;
        prev_bp  = 1'b0;
    endtask

    // A level flips once the last CNT_MAX samples since the previous flip all
    // disagree with it; a flip to pressed produces the pulse.
    task automatic mdl_edge(input logic ka, input logic kb);
        logic [1:0] s;
        bit         ok;
        raw_h.push_back({kb == 1'b0, ka == 1'b0});
        s = (raw_h.size() >= 3) ? raw_h[raw_h.size() - 3] : 2'b00;
        s_h.push_back(s);
        m_press = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (s_h.size() - since[c] >= CMI) begin
                ok = 1'b1;
                for (int k = 1; k <= CMI; k++)
                    if (s_h[s_h.size() - k][c] == m_lvl[c]) ok = 1'b0;
                if (ok) begin
                    m_lvl[c]   = ~m_lvl[c];
                    m_press[c] = m_lvl[c];
                    since[c]   = s_h.size();
                end
            end
        end
    endtask

    // One clock edge: update the model, then compare just after the edge.
    task automatic tick();
        int run;
        @(posedge sys_clk);
        mdl_edge(key_a, key_b);
        #1;
        chk("a_lvl",   a_lvl,   m_lvl[0]);
        chk("b_lvl",   b_lvl,   m_lvl[1]);
        chk("a_press", a_press, m_press[0]);
        chk("b_press", b_press, m_press[1]);
        chk("a_press_gap", prev_ap & a_press, 1'b0);
        chk("b_press_gap", prev_bp & b_press, 1'b0);
        if (a_press) begin
            run = 0;
            for (int i = raw_h.size() - 3; i >= 0 && raw_h[i][0]; i--) run++;
            chk("a_press_stable", run >= CMI, 1'b1);
        end
        prev_ap = a_press;
        prev_bp = b_press;
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_a_lvl",   a_lvl,   1'b0);
        chk("rst_b_lvl",   b_lvl,   1'b0);
        chk("rst_a_press", a_press, 1'b0);
        chk("rst_b_press", b_press, 1'b0);
        mdl_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        key_a     = 1'b1;
        key_b     = 1'b1;
        sys_rst_n = 1'b0;
        mdl_reset();
        #2;
        do_reset();

        // Clean press of A: accepted on edge 6, pulse gone on edge 7.
        key_a = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) chk("t1_lvl_e5", a_lvl, 1'b0);
            if (e == 6) begin
                chk("t1_lvl_e6",   a_lvl,   1'b1);
                chk("t1_press_e6", a_press, 1'b1);
            end
            if (e == 7) chk("t1_press_e7", a_press, 1'b0);
        end

        // Short release glitch while held: level stays, no second pulse.
        key_a = 1'b1;
        repeat (2) tick();
        key_a = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t3_lvl_held", a_lvl,   1'b1);
            chk("t3_no_press", a_press, 1'b0);
        end
        key_a = 1'b1;
        repeat (8) tick();
        chk("t3_released", a_lvl, 1'b0);

        // Press shorter than CNT_MAX samples is ignored.
        key_a = 1'b0;
        repeat (3) tick();
        key_a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t2_lvl",   a_lvl,   1'b0);
            chk("t2_press", a_press, 1'b0);
        end

        // Simultaneous press on both keys: both pulse on edge 6.
        key_a = 1'b0;
        key_b = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 6) begin
                chk("t4_a_press", a_press, 1'b1);
                chk("t4_b_press", b_press, 1'b1);
            end
        end
        repeat (4) tick();
        chk("t4_b_lvl", b_lvl, 1'b1);

        // Reset while both levels are high clears everything immediately.
        do_reset();

        // Reset at edge 4 of a press; key still held afterwards.
        key_a = 1'b1;
        key_b = 1'b1;
        repeat (8) tick();
        key_a = 1'b0;
        repeat (4) tick();
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) chk("t5_press_e5", a_press, 1'b0);
            if (e == 6) chk("t5_press_e6", a_press, 1'b1);
            if (e == 7) chk("t5_press_e7", a_press, 1'b0);
        end

        // Random toggling with mixed hold lengths on both keys.
        begin
            int hold_a = 0;
            int hold_b = 0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                if (hold_a == 0) begin
                    key_a  = 1'($urandom_range(0, 1));
                    hold_a = int'($urandom_range(1, 7));
                end
                if (hold_b == 0) begin
                    key_b  = 1'($urandom_range(0, 1));
                    hold_b = int'($urandom_range(1, 7));
                end
                hold_a--;
                hold_b--;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
